// File: rtl/atm_pkg.sv
// Shared constants and types for the ATM keypad front-end and controller.
// Key codes, entry kinds, accumulator operations and the entry FSM states live here.
package atm_pkg;

  localparam int VALUE_W = 19;
  localparam int PIN_W   = 17;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_BACK   = 4'hB;
  localparam logic [3:0] KEY_ENTER  = 4'hC;
  localparam logic [3:0] KEY_CANCEL = 4'hD;

  typedef enum logic [1:0] {
    KIND_PIN  = 2'd0,
    KIND_ACCT = 2'd1,
    KIND_AMT  = 2'd2,
    KIND_RSVD = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    ACC_NOP,
    ACC_PUSH,
    ACC_BACK,
    ACC_CLEAR
  } acc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HOLD
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_dec_accum.sv
// Decimal accumulator: holds the entered value in binary plus the digit count.
// The caller guarantees PUSH only below the digit limit and BACK only with count>0.
module atm_dec_accum
  import atm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  acc_op_t            op,
  input  logic [3:0]         digit,
  output logic [VALUE_W-1:0] acc,
  output logic [2:0]         count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else begin
      case (op)
        ACC_PUSH: begin
          // acc*10 as two shifts; max 9999*10+9 fits comfortably in VALUE_W
          acc   <= (acc << 3) + (acc << 1) + VALUE_W'(digit);
          count <= count + 3'd1;
        end
        ACC_BACK: begin
          acc   <= acc / VALUE_W'(10);
          count <= count - 3'd1;
        end
        ACC_CLEAR: begin
          acc   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry front-end: collects digits for PIN/account/amount, hands the value off
// on a valid/ready handshake, and raises one-cycle Timer (inactivity) and cancel pulses.
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int PIN_DIGITS     = 4,
  parameter int ACCT_DIGITS    = 5,
  parameter int AMT_DIGITS     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         kind,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  input  logic               entry_ready,
  output logic [VALUE_W-1:0] entry_value,
  output logic               entry_valid,
  output logic [2:0]         digit_count,
  output logic               busy,
  output logic               Timer,
  output logic               entry_cancel
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Handshake: entry_valid rises with entry_value held stable; the transfer happens on the
  // first rising edge where entry_valid && entry_ready, and entry_valid drops after that edge.

  entry_state_t       state, state_nxt;
  kind_t              kind_q, kind_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  acc_op_t            acc_op;
  logic [VALUE_W-1:0] acc;
  logic [2:0]         count;
  logic [2:0]         max_digits;
  logic               enter_ok;
  logic               key_hit;
  logic               timer_fire;
  logic               cancel_fire;

  atm_dec_accum u_accum (
    .clk   (clk),
    .rst_n (reset),
    .op    (acc_op),
    .digit (key_code),
    .acc   (acc),
    .count (count)
  );

  always_comb begin
    max_digits = 3'(AMT_DIGITS);
    enter_ok   = (count >= 3'd1) && (count <= 3'(AMT_DIGITS)) && (acc != '0);
    case (kind_q)
      KIND_PIN: begin
        max_digits = 3'(PIN_DIGITS);
        enter_ok   = (count == 3'(PIN_DIGITS));
      end
      KIND_ACCT: begin
        max_digits = 3'(ACCT_DIGITS);
        enter_ok   = (count == 3'(ACCT_DIGITS));
      end
      default: ;
    endcase
  end

  // E/F are not decoded keys: they neither act nor restart the timer
  assign key_hit = key_valid && (key_code <= KEY_CANCEL);

  always_comb begin
    state_nxt   = state;
    kind_nxt    = kind_q;
    timer_nxt   = timer;
    acc_op      = ACC_NOP;
    timer_fire  = 1'b0;
    cancel_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (kind_t'(kind) != KIND_RSVD)) begin
          kind_nxt  = kind_t'(kind);
          acc_op    = ACC_CLEAR;
          timer_nxt = '0;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (key_hit) begin
          timer_nxt = '0;
          if (is_digit(key_code)) begin
            if (count < max_digits) acc_op = ACC_PUSH;
          end else begin
            case (key_code)
              KEY_CLEAR: acc_op = ACC_CLEAR;
              KEY_BACK:  if (count != 3'd0) acc_op = ACC_BACK;
              KEY_ENTER: if (enter_ok) state_nxt = ST_HOLD;
              default: begin
                cancel_fire = 1'b1;
                acc_op      = ACC_CLEAR;
                state_nxt   = ST_IDLE;
              end
            endcase
          end
        end else if (timer == TIMER_LAST) begin
          timer_fire = 1'b1;
          timer_nxt  = '0;
          acc_op     = ACC_CLEAR;
          state_nxt  = ST_IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_HOLD: begin
        if (entry_ready) begin
          acc_op    = ACC_CLEAR;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      kind_q       <= KIND_PIN;
      timer        <= '0;
      entry_value  <= '0;
      entry_valid  <= 1'b0;
      busy         <= 1'b0;
      Timer        <= 1'b0;
      entry_cancel <= 1'b0;
    end else begin
      state        <= state_nxt;
      kind_q       <= kind_nxt;
      timer        <= timer_nxt;
      // acc is untouched by ENTER and frozen in HOLD, so capturing it here is exact
      entry_value  <= (state_nxt == ST_HOLD) ? acc : '0;
      entry_valid  <= (state_nxt == ST_HOLD);
      busy         <= (state_nxt != ST_IDLE);
      Timer        <= timer_fire;
      entry_cancel <= cancel_fire;
    end
  end

  assign digit_count = count;

endmodule
